rob_ptr_ctrl: RTL and testbench

//  Head/tail pointer and commit controller for the 32-entry reorder buffer done-bit array.

---
 rtl/rob_pkg.sv | 13 +
 rtl/rob_ptr_inc.sv | 13 +
 rtl/rob_ptr_ctrl.sv | 76 +++++++
 tb/tb_rob_ptr_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer pointer/commit controller.
package rob_pkg;

    localparam int ROB_DEPTH = 32;

    typedef logic [4:0] rob_idx_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } rob_state_e;

endpackage

// File: rtl/rob_ptr_inc.sv
// Wrap-around increment of a ROB index; the modulo comes from the natural width overflow.
module rob_ptr_inc
    import rob_pkg::*;
#(
    parameter int W = $clog2(ROB_DEPTH)
) (
    input  logic [W-1:0] idx,
    output logic [W-1:0] idx_nxt
);

    assign idx_nxt = idx + W'(1);

endmodule

// File: rtl/rob_ptr_ctrl.sv
// Head/tail pointer and commit controller for the reorder-buffer done-bit array.
module rob_ptr_ctrl
    import rob_pkg::*;
#(
    parameter int S_INDEX = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_req,
    output logic               alloc_ack,
    output logic [S_INDEX-1:0] alloc_idx,
    output logic               clr_en,
    output logic [S_INDEX-1:0] clr_idx,
    input  logic               commit_ready,
    input  logic               commit_stall,
    output logic               rd_en,
    output logic [S_INDEX-1:0] rd_idx,
    input  logic               flush,
    input  logic [S_INDEX-1:0] flush_idx,
    output logic               full,
    output logic               empty,
    output logic [S_INDEX:0]   count
);

    localparam int DEPTH = 2 ** S_INDEX;

    logic [S_INDEX-1:0] head;
    logic [S_INDEX-1:0] tail;
    logic [S_INDEX-1:0] head_nxt;
    logic [S_INDEX-1:0] tail_nxt;
    logic [S_INDEX-1:0] flush_nxt;
    logic [S_INDEX-1:0] flush_off;
    rob_state_e         state;

    rob_ptr_inc #(.W(S_INDEX)) u_head_inc  (.idx(head),      .idx_nxt(head_nxt));
    rob_ptr_inc #(.W(S_INDEX)) u_tail_inc  (.idx(tail),      .idx_nxt(tail_nxt));
    rob_ptr_inc #(.W(S_INDEX)) u_flush_inc (.idx(flush_idx), .idx_nxt(flush_nxt));

    assign full      = (count == (S_INDEX+1)'(DEPTH));
    assign empty     = (count == '0);
    assign rd_idx    = head;
    assign alloc_idx = tail;
    assign clr_idx   = tail;
    // Distance from head to the kept branch; wraps naturally in S_INDEX bits.
    assign flush_off = flush_idx - head;

    always_comb begin
        alloc_ack = alloc_req && !full && (state == RUN) && !flush;
        rd_en     = !empty && commit_ready && !commit_stall && (state == RUN) && !flush;
        clr_en    = alloc_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= RUN;
        end else if (flush) begin
            assert ({1'b0, flush_off} < count);
            tail  <= flush_nxt;
            count <= {1'b0, flush_off} + (S_INDEX+1)'(1);
            state <= RECOVER;
        end else begin
            state <= RUN;
            if (alloc_ack) tail <= tail_nxt;
            if (rd_en)     head <= head_nxt;
            case ({alloc_ack, rd_en})
                2'b10:   count <= count + (S_INDEX+1)'(1);
                2'b01:   count <= count - (S_INDEX+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// Directed bench for rob_ptr_ctrl with hand-computed expected values.
module tb_rob_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic       alloc_ack;
    logic [4:0] alloc_idx;
    logic       clr_en;
    logic [4:0] clr_idx;
    logic       commit_ready;
    logic       commit_stall;
    logic       rd_en;
    logic [4:0] rd_idx;
    logic       flush;
    logic [4:0] flush_idx;
    logic       full;
    logic       empty;
    logic [5:0] count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rob_ptr_ctrl #(.S_INDEX(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_ack    (alloc_ack),
        .alloc_idx    (alloc_idx),
        .clr_en       (clr_en),
        .clr_idx      (clr_idx),
        .commit_ready (commit_ready),
        .commit_stall (commit_stall),
        .rd_en        (rd_en),
        .rd_idx       (rd_idx),
        .flush        (flush),
        .flush_idx    (flush_idx),
        .full         (full),
        .empty        (empty),
        .count        (count)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs then change and settle before sampling.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        alloc_req    = 1'b0;
        commit_ready = 1'b0;
        commit_stall = 1'b0;
        flush        = 1'b0;
        flush_idx    = '0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("rst_ack",   int'(alloc_ack), 0);
        check("rst_clr",   int'(clr_en),    0);
        check("rst_rd_en", int'(rd_en),     0);
        check("rst_full",  int'(full),      0);
        check("rst_empty", int'(empty),     1);
        check("rst_count", int'(count),     0);
        check("rst_rdidx", int'(rd_idx),    0);
        check("rst_aidx",  int'(alloc_idx), 0);

        // Fill all 32 slots with no commits.
        for (int i = 0; i < 32; i++) begin
            alloc_req = 1'b1;
            settle();
            check("fill_ack",  int'(alloc_ack), 1);
            check("fill_aidx", int'(alloc_idx), i);
            check("fill_clr",  int'(clr_en),    1);
            check("fill_cidx", int'(clr_idx),   i);
            tick();
        end
        check("full_flag",  int'(full),  1);
        check("full_count", int'(count), 32);
        check("full_empty", int'(empty), 0);
        check("ovf_ack",    int'(alloc_ack), 0);
        check("ovf_clr",    int'(clr_en),    0);

        // Drain in order; first cycle also proves full rejects alloc despite a commit.
        commit_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            alloc_req = (i == 0);
            settle();
            check("drain_rd_en", int'(rd_en),  1);
            check("drain_rdidx", int'(rd_idx), i);
            if (i == 0) check("full_commit_ack", int'(alloc_ack), 0);
            tick();
        end
        alloc_req = 1'b0;
        settle();
        check("drain_empty", int'(empty),  1);
        check("drain_count", int'(count),  0);
        check("drain_wrap",  int'(rd_idx), 0);
        check("drain_full",  int'(full),   0);
        check("empty_rd_en", int'(rd_en),  0);

        // Build count=5, then alloc and retire together.
        commit_ready = 1'b0;
        alloc_req    = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("five_count", int'(count), 5);
        commit_ready = 1'b1;
        settle();
        check("both_ack",   int'(alloc_ack), 1);
        check("both_rd_en", int'(rd_en),     1);
        tick();
        alloc_req = 1'b0;
        check("both_count", int'(count),     5);
        check("both_head",  int'(rd_idx),    1);
        check("both_tail",  int'(alloc_idx), 6);

        // Stall holds the head; release retires the same index.
        commit_stall = 1'b1;
        settle();
        check("stall_rd_en", int'(rd_en), 0);
        tick();
        check("stall_head",  int'(rd_idx), 1);
        check("stall_count", int'(count),  5);
        commit_stall = 1'b0;
        settle();
        check("unstall_rd_en", int'(rd_en),  1);
        check("unstall_rdidx", int'(rd_idx), 1);
        tick();
        commit_ready = 1'b0;
        check("unstall_head",  int'(rd_idx), 2);
        check("unstall_count", int'(count),  4);

        // Position head=30, tail=4, count=6.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        alloc_req = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        alloc_req    = 1'b0;
        commit_ready = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        commit_ready = 1'b0;
        check("pos_head",  int'(rd_idx), 30);
        check("pos_empty", int'(empty),  1);
        alloc_req = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("pos_count", int'(count),     6);
        check("pos_tail",  int'(alloc_idx), 4);

        // Flush at idx 1 with alloc and commit also requested.
        commit_ready = 1'b1;
        flush        = 1'b1;
        flush_idx    = 5'd1;
        settle();
        check("flush_ack",   int'(alloc_ack), 0);
        check("flush_rd_en", int'(rd_en),     0);
        tick();
        flush = 1'b0;
        check("rec_tail",  int'(alloc_idx), 2);
        check("rec_count", int'(count),     4);
        check("rec_ack",   int'(alloc_ack), 0);
        check("rec_rd_en", int'(rd_en),     0);

        // Reapply flush while recovering: head=30, keep up to idx 0.
        flush     = 1'b1;
        flush_idx = 5'd0;
        tick();
        flush = 1'b0;
        check("rec2_tail",  int'(alloc_idx), 1);
        check("rec2_count", int'(count),     3);
        check("rec2_ack",   int'(alloc_ack), 0);
        check("rec2_rd_en", int'(rd_en),     0);
        tick();
        check("run_ack",   int'(alloc_ack), 1);
        check("run_rd_en", int'(rd_en),     1);
        check("run_rdidx", int'(rd_idx),    30);
        tick();
        check("run_count", int'(count),     3);
        check("run_tail",  int'(alloc_idx), 2);
        check("run_head",  int'(rd_idx),    31);

        // count=7 then flush keeping idx 5 (offset 6 from head 31).
        commit_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre7_count", int'(count), 7);
        flush     = 1'b1;
        flush_idx = 5'd5;
        tick();
        check("f7_count", int'(count),     7);
        check("f7_tail",  int'(alloc_idx), 6);
        check("f7_ack",   int'(alloc_ack), 1 - 1);

        // Reset in RECOVER, alongside another flush: reset wins.
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        settle();
        check("rr_count", int'(count),     0);
        check("rr_empty", int'(empty),     1);
        check("rr_head",  int'(rd_idx),    0);
        check("rr_tail",  int'(alloc_idx), 0);
        check("rr_run",   int'(alloc_ack), 1);
        alloc_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
